bsg_counter_clock_downsample_ctrl: RTL and testbench
====================================================

BSG_COUNTER_CLOCK_DOWNSAMPLE_CTRL -- requirements
Module: bsg_counter_clock_downsample_ctrl

Interface
REQ-001 The block SHALL have parameter width_p, default 16, giving the divisor width (matches the downsampler val_i).
REQ-002 The block SHALL have parameter init_val_p, default 0, giving the divisor driven after reset.
REQ-003 The block SHALL have parameter hold_cycles_p, default 2, minimum 1, giving the number of cycles ds_reset_o is held per restart.
REQ-004 The block SHALL have parameter lock_toggles_p, default 2, minimum 1, giving the number of ds_clk_r_i toggles required before lock.
REQ-005 The block SHALL have port clk_i, input, width 1: the single clock, shared with the downsampler.
REQ-006 The block SHALL have port reset_n_i, input, width 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port v_i, input, width 1: a configuration write is offered.
REQ-008 The block SHALL have port val_i, input, width_p: the new divisor value.
REQ-009 The block SHALL have port restart_i, input, width 1: qualifies v_i; a write with restart_i high also restarts the downsampler.
REQ-010 The block SHALL have port ready_o, output, width 1: the block can accept a write.
REQ-011 The block SHALL have port ds_val_o, output, width_p: the divisor, connected to the downsampler val_i.
REQ-012 The block SHALL have port ds_reset_o, output, width 1: active-high synchronous reset, connected to the downsampler reset_i.
REQ-013 The block SHALL have port ds_clk_r_i, input, width 1: the downsampler clk_r_o, registered in the clk_i domain.
REQ-014 The block SHALL have port locked_o, output, width 1: the divided clock has toggled lock_toggles_p times since the last restart.

Function
REQ-015 A write SHALL be accepted on a rising edge of clk_i where v_i & ready_o is high; v_i is ignored when ready_o is low.
REQ-016 The FSM SHALL have states RESET, WAIT_LOCK and IDLE.
REQ-017 ready_o SHALL be 1 only in IDLE.
REQ-018 locked_o SHALL be 1 only in IDLE after a completed lock.
REQ-019 ds_reset_o SHALL be a flop output equal to 1 exactly while in RESET.
REQ-020 On an accepted write, ds_val_o SHALL take val_i on the same edge, with a registered path and no combinational path from val_i.
REQ-021 An accepted write with restart_i=1 SHALL move the FSM to RESET on the same edge, clear the hold counter, and clear locked_o.
REQ-022 An accepted write with restart_i=0 SHALL update only ds_val_o; the state stays IDLE and locked_o is unchanged.
REQ-023 RESET SHALL last exactly hold_cycles_p cycles, so ds_reset_o is high for hold_cycles_p consecutive cycles, then the FSM moves to WAIT_LOCK.
REQ-024 On entry to WAIT_LOCK, the block SHALL sample ds_clk_r_i into a previous-value flop and clear the toggle counter.
REQ-025 In WAIT_LOCK, each cycle where ds_clk_r_i differs from the previous-value flop SHALL count one toggle.
REQ-026 When the toggle count reaches lock_toggles_p, the next edge SHALL move the FSM to IDLE and set locked_o=1; ready_o rises on the same edge.
REQ-027 Toggles outside WAIT_LOCK SHALL be ignored.
REQ-028 The toggle counter SHALL saturate and never wrap.
REQ-029 WAIT_LOCK has no timeout: with a stuck ds_clk_r_i the block SHALL remain in WAIT_LOCK with ready_o=0.
REQ-030 All counters SHALL be sized $clog2(param+1) bits; the hold counter is compared with hold_cycles_p-1.

Reset
REQ-031 On reset_n_i low, asynchronously, all flops SHALL take these values: state=RESET, hold counter=0, toggle counter=0, ds_reset_o=1, ds_val_o=init_val_p, locked_o=0, ready_o=0.
REQ-032 After reset_n_i deasserts, ds_reset_o SHALL stay high for hold_cycles_p further cycles, then follow the normal RESET to WAIT_LOCK to IDLE sequence.
REQ-033 Reset asserted mid-operation (any state) SHALL abort immediately, with no pending write retained.

Structure
REQ-034 The state enum bsg_clk_ds_ctrl_state_e (RESET, WAIT_LOCK, IDLE) SHALL live in the shared package bsg_clk_ds_ctrl_pkg.
REQ-035 Toggle detection and counting SHALL be one sub-module, bsg_clk_ds_lock_detect, with inputs clk_i, reset_n_i, clear_i, en_i, sig_i and output done_o; it is parameterized by lock_toggles_p.
REQ-036 The block SHALL contain no latches, no gated clocks, and no combinational path from v_i to ready_o.

Verification
REQ-037 Reset release, default parameters, ds_clk_r_i toggling every 3 cycles -> ds_reset_o=1 for 2 cycles after release, locked_o=1 one cycle after the 2nd toggle, ds_val_o=0.
REQ-038 In IDLE, write val_i=16'h0005, restart_i=1 -> ds_val_o=5 next cycle, ready_o=0 and locked_o=0 at once, ds_reset_o high exactly 2 cycles, relock after 2 toggles.
REQ-039 In IDLE and locked, write val_i=16'h00FF, restart_i=0 -> ds_val_o=FF, ds_reset_o stays 0, locked_o stays 1, ready_o stays 1.
REQ-040 v_i held high with val_i=16'h1234 during WAIT_LOCK -> no acceptance, ds_val_o unchanged; accepted on the first IDLE cycle.
REQ-041 ds_clk_r_i held constant in WAIT_LOCK for 1000 cycles -> locked_o=0 and ready_o=0 throughout.
REQ-042 reset_n_i pulsed low for half a cycle in WAIT_LOCK -> outputs reach reset values asynchronously, and the RESET hold of hold_cycles_p cycles is repeated.

Source files
------------

// File: rtl/bsg_clk_ds_ctrl_pkg.sv
// Shared types for the clock-downsampler controller: the sequencing states.
package bsg_clk_ds_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        IDLE      = 2'd2
    } bsg_clk_ds_ctrl_state_e;

endpackage

// File: rtl/bsg_clk_ds_lock_detect.sv
// Counts edges of the registered divided clock; done_o once lock_toggles_p edges have been seen.
module bsg_clk_ds_lock_detect #(
    parameter int lock_toggles_p = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic sig_i,
    output logic done_o
);

    localparam int TW = $clog2(lock_toggles_p + 1);
    localparam logic [TW-1:0] TOG_TARGET = TW'(lock_toggles_p);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;

    always_comb begin
        cnt_d  = cnt_q;
        prev_d = sig_i;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (sig_i != prev_q) && (cnt_q != TOG_TARGET)) begin
            // Saturates at the target so a fast divided clock cannot wrap it.
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end

    assign done_o = (cnt_q == TOG_TARGET);

endmodule

// File: rtl/bsg_counter_clock_downsample_ctrl.sv
// Programs a clock downsampler: holds its reset on restart, then waits for the divided clock to lock.
module bsg_counter_clock_downsample_ctrl
    import bsg_clk_ds_ctrl_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int init_val_p     = 0,
    parameter int hold_cycles_p  = 2,
    parameter int lock_toggles_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] val_i,
    input  logic               restart_i,
    output logic               ready_o,
    output logic [width_p-1:0] ds_val_o,
    output logic               ds_reset_o,
    input  logic               ds_clk_r_i,
    output logic               locked_o
);

    localparam int HW = $clog2(hold_cycles_p + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(hold_cycles_p - 1);

    bsg_clk_ds_ctrl_state_e state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [width_p-1:0]     ds_val_q, ds_val_d;
    logic                   ds_reset_q, ds_reset_d;
    logic                   ready_q, ready_d;
    logic                   locked_q, locked_d;

    logic accept;
    logic lock_clear;
    logic lock_en;
    logic lock_done;

    // ready_q is a flop, so v_i never reaches ready_o combinationally.
    assign accept     = v_i & ready_q;
    assign lock_clear = (state_q == RESET) && (hold_q == HOLD_LAST);
    assign lock_en    = (state_q == WAIT_LOCK);

    bsg_clk_ds_lock_detect #(
        .lock_toggles_p(lock_toggles_p)
    ) u_lock_detect (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (lock_clear),
        .en_i     (lock_en),
        .sig_i    (ds_clk_r_i),
        .done_o   (lock_done)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ds_val_d = ds_val_q;
        locked_d = locked_q;
        case (state_q)
            RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_done) begin
                    state_d  = IDLE;
                    locked_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    ds_val_d = val_i;
                    if (restart_i) begin
                        state_d  = RESET;
                        hold_d   = '0;
                        locked_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = RESET;
                hold_d   = '0;
                locked_d = 1'b0;
            end
        endcase
        ds_reset_d = (state_d == RESET);
        ready_d    = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= RESET;
            hold_q     <= '0;
            ds_val_q   <= width_p'(init_val_p);
            ds_reset_q <= 1'b1;
            ready_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            ds_val_q   <= ds_val_d;
            ds_reset_q <= ds_reset_d;
            ready_q    <= ready_d;
            locked_q   <= locked_d;
        end
    end

    assign ready_o    = ready_q;
    assign ds_val_o   = ds_val_q;
    assign ds_reset_o = ds_reset_q;
    assign locked_o   = locked_q;

endmodule

// File: tb/tb_bsg_counter_clock_downsample_ctrl.sv
// Randomized bench for the downsampler controller against a phase-based reference model.
module tb_bsg_counter_clock_downsample_ctrl;

    localparam int W = 16;
    localparam int H = 2;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         v = 1'b0;
    logic [W-1:0] val = '0;
    logic         restart = 1'b0;
    logic         ds_clk = 1'b0;
    logic         ready_o, ds_reset_o, locked_o;
    logic [W-1:0] ds_val_o;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = holding downsampler reset, 1 = waiting for lock, 2 = configured.
    int           m_phase;
    int           m_hold_left;
    int           m_edges;
    logic         m_last_clk;
    logic         m_locked;
    logic [W-1:0] m_val;

    int gen_period = 3;
    int gen_cnt = 0;

    bsg_counter_clock_downsample_ctrl #(
        .width_p(W), .init_val_p(0), .hold_cycles_p(H), .lock_toggles_p(L)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .val_i(val), .restart_i(restart),
        .ready_o(ready_o), .ds_val_o(ds_val_o), .ds_reset_o(ds_reset_o),
        .ds_clk_r_i(ds_clk), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W+2:0] expected();
        return {m_phase == 0, m_phase == 2, m_locked, m_val};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hold_left = H; m_edges = 0;
        m_last_clk = 1'b0; m_locked = 1'b0; m_val = '0;
    endtask

    // Advance one clock: the model consumes the inputs present before the edge.
    task automatic cycle();
        logic         cv, crs, cclk;
        logic [W-1:0] cval;
        cv = v; crs = restart; cclk = ds_clk; cval = val;
        @(posedge clk);
        #1;
        if (m_phase == 2) begin
            if (cv) begin
                m_val = cval;
                if (crs) begin
                    m_phase = 0; m_hold_left = H; m_locked = 1'b0;
                end
            end
        end else if (m_phase == 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_phase = 1; m_edges = 0; m_last_clk = cclk;
            end
        end else begin
            if (m_edges >= L) begin
                m_phase = 2; m_locked = 1'b1;
            end else begin
                if (cclk != m_last_clk) m_edges++;
                m_last_clk = cclk;
            end
        end
        if (gen_period != 0) begin
            gen_cnt++;
            if (gen_cnt >= gen_period) begin
                ds_clk = ~ds_clk;
                gen_cnt = 0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values got rst=%b rdy=%b lck=%b val=%h want 1 0 0 0000",
                     ds_reset_o, ready_o, locked_o, ds_val_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock_sequence();
        int rst_cycles;
        gen_period = 3; gen_cnt = 0;
        rst_cycles = int'(ds_reset_o);
        for (int i = 0; i < 30; i++) begin
            cycle();
            rst_cycles += int'(ds_reset_o);
            checks++;
            if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== expected()) begin
                errors++;
                $display("FAIL lock_seq cyc=%0d got %h want %h", i,
                         {ds_reset_o, ready_o, locked_o, ds_val_o}, expected());
            end
        end
        checks++;
        if (rst_cycles != H || locked_o !== 1'b1 || ds_val_o !== 16'h0000) begin
            errors++;
            $display("FAIL lock_seq_summary got rst_cycles=%0d lck=%b val=%h want %0d 1 0000",
                     rst_cycles, locked_o, ds_val_o, H);
        end
    endtask

    task automatic test_restart_write();
        int rst_cycles;
        v = 1'b1; val = 16'h0005; restart = 1'b1;
        cycle();
        v = 1'b0; restart = 1'b0;
        checks++;
        if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== {1'b1, 1'b0, 1'b0, 16'h0005}) begin
            errors++;
            $display("FAIL restart_accept got rst=%b rdy=%b lck=%b val=%h want 1 0 0 0005",
                     ds_reset_o, ready_o, locked_o, ds_val_o);
        end
        rst_cycles = 1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            rst_cycles += int'(ds_reset_o);
            checks++;
            if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== expected()) begin
                errors++;
                $display("FAIL restart_seq cyc=%0d got %h want %h", i,
                         {ds_reset_o, ready_o, locked_o, ds_val_o}, expected());
            end
        end
        checks++;
        if (rst_cycles != H || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_relock got rst_cycles=%0d lck=%b want %0d 1",
                     rst_cycles, locked_o, H);
        end
    endtask

    task automatic test_norestart_write();
        v = 1'b1; val = 16'h00FF; restart = 1'b0;
        cycle();
        v = 1'b0;
        checks++;
        if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== {1'b0, 1'b1, 1'b1, 16'h00FF}) begin
            errors++;
            $display("FAIL norestart_write got rst=%b rdy=%b lck=%b val=%h want 0 1 1 00ff",
                     ds_reset_o, ready_o, locked_o, ds_val_o);
        end
    endtask

    task automatic test_write_during_wait();
        logic seen_idle;
        v = 1'b1; val = 16'h0007; restart = 1'b1;
        cycle();
        restart = 1'b0; v = 1'b0;
        repeat (H) cycle();
        v = 1'b1; val = 16'h1234;
        seen_idle = 1'b0;
        for (int i = 0; i < 40 && !seen_idle; i++) begin
            cycle();
            checks++;
            if (ds_val_o !== 16'h0007 || ready_o !== (m_phase == 2)) begin
                errors++;
                $display("FAIL blocked_write cyc=%0d got val=%h rdy=%b want 0007 %b",
                         i, ds_val_o, ready_o, m_phase == 2);
            end
            seen_idle = (m_phase == 2);
        end
        cycle();
        v = 1'b0;
        checks++;
        if (!seen_idle || ds_val_o !== 16'h1234 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL first_idle_accept got val=%h rdy=%b idle=%b want 1234 1 1",
                     ds_val_o, ready_o, seen_idle);
        end
    endtask

    task automatic test_stuck_clock();
        v = 1'b1; val = 16'h0003; restart = 1'b1;
        cycle();
        v = 1'b0; restart = 1'b0;
        gen_period = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            checks++;
            if (locked_o !== 1'b0 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stuck_clock cyc=%0d got lck=%b rdy=%b want 0 0", i, locked_o, ready_o);
            end
        end
        gen_period = 2; gen_cnt = 0;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (locked_o !== 1'b1 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL unstuck_relock got lck=%b rdy=%b want 1 1", locked_o, ready_o);
        end
    endtask

    task automatic test_async_reset_pulse();
        int rst_cycles;
        v = 1'b1; val = 16'h0042; restart = 1'b1;
        cycle();
        v = 1'b0; restart = 1'b0;
        repeat (H + 1) cycle();
        v = 1'b1; val = 16'h0BAD;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL async_reset got rst=%b rdy=%b lck=%b val=%h want 1 0 0 0000",
                     ds_reset_o, ready_o, locked_o, ds_val_o);
        end
        #2;
        reset_n = 1'b1;
        v = 1'b0;
        model_reset();
        m_last_clk = ds_clk;
        rst_cycles = int'(ds_reset_o);
        for (int i = 0; i < 20; i++) begin
            cycle();
            rst_cycles += int'(ds_reset_o);
            checks++;
            if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== expected()) begin
                errors++;
                $display("FAIL post_pulse cyc=%0d got %h want %h", i,
                         {ds_reset_o, ready_o, locked_o, ds_val_o}, expected());
            end
        end
        checks++;
        if (rst_cycles != H) begin
            errors++;
            $display("FAIL post_pulse_hold got %0d want %0d", rst_cycles, H);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 2) == 0);
            val = W'($urandom);
            if ($urandom_range(0, 40) == 0) gen_period = $urandom_range(0, 5);
            if (gen_period == 0 && $urandom_range(0, 10) == 0) gen_period = 1;
            cycle();
            checks++;
            if ({ds_reset_o, ready_o, locked_o, ds_val_o} !== expected()) begin
                errors++;
                $display("FAIL random cyc=%0d got %h want %h", i,
                         {ds_reset_o, ready_o, locked_o, ds_val_o}, expected());
            end
        end
        v = 1'b0; restart = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_sequence();
        test_restart_write();
        test_norestart_write();
        test_write_during_wait();
        test_stuck_clock();
        test_async_reset_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
